// File: rtl/mips_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline control: forwarding selects,
// sequencer states and the hardwired zero register.
package mips_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // $0 is hardwired, so it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding selects for both ALU operands.
// Purely combinational (0-cycle); no flow control.
module fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_wreg,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_wreg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // The younger result in EX/MEM shadows the older one in MEM/WB.
  function automatic logic [1:0] pick(input logic [4:0] src);
    if (mem_regwrite && reg_match(mem_wreg, src)) return FWD_EXMEM;
    if (wb_regwrite && reg_match(wb_wreg, src))   return FWD_MEMWB;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = pick(ex_rs);
    fwd_b = pick(ex_rt);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes, forwarding selects, memory freeze, statistics.
// All decisions are 0-cycle combinational; a busy data memory freezes every stage.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             ex_jump,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_wreg,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_wreg,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

  state_t           state, state_nxt;
  logic             pend_br, pend_br_nxt;
  logic             pend_jmp, pend_jmp_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             load_use, freeze, stall_ev, flush_ev, br, jmp;

  fwd_unit u_fwd (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  assign load_use = ex_memread &&
                    ((id_uses_rs && reg_match(ex_rt, id_rs)) ||
                     (id_uses_rt && reg_match(ex_rt, id_rt)));

  // A branch/jump seen while entering the freeze is replayed on the release cycle.
  assign br  = mem_branch_taken || pend_br;
  assign jmp = ex_jump || pend_jmp;

  always_comb begin
    state_nxt    = state;
    pend_br_nxt  = pend_br;
    pend_jmp_nxt = pend_jmp;
    freeze       = 1'b0;
    stall_ev     = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;

    case (state)
      ST_RUN: begin
        if (mem_access && !dmem_ready) begin
          freeze       = 1'b1;
          state_nxt    = ST_MEM_WAIT;
          pend_br_nxt  = mem_branch_taken;
          pend_jmp_nxt = ex_jump;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          freeze = 1'b1;
        end else begin
          state_nxt    = ST_RUN;
          pend_br_nxt  = 1'b0;
          pend_jmp_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (freeze) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      stall_ev = 1'b1;
    end else if (br) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (jmp) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_ev   = 1'b1;
    end

    if (!RST_N) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end
  end

  assign flush_ev = ifid_flush || idex_flush || exmem_flush;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_RUN;
      pend_br     <= 1'b0;
      pend_jmp    <= 1'b0;
      tmo_cnt     <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      pend_br  <= pend_br_nxt;
      pend_jmp <= pend_jmp_nxt;

      if (state == ST_MEM_WAIT && !dmem_ready) begin
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (tmo_cnt == TMO_LAST) mem_timeout <= 1'b1;
      end else begin
        tmo_cnt <= '0;
      end

      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; narrow counters make saturation reachable.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int MEM_TMO = 255;

  // Packed view: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
  localparam logic [7:0] CTL_RUN    = 8'b11111_000;
  localparam logic [7:0] CTL_FREEZE = 8'b00000_000;
  localparam logic [7:0] CTL_LU     = 8'b00111_010;
  localparam logic [7:0] CTL_BR     = 8'b11111_111;
  localparam logic [7:0] CTL_JMP    = 8'b11111_110;
  localparam logic [7:0] CTL_RST    = 8'b00000_111;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_wreg, wb_wreg;
  logic id_uses_rs, id_uses_rt, ex_memread, ex_jump, mem_regwrite, wb_regwrite;
  logic mem_branch_taken, mem_access, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_jump(ex_jump),
    .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_memread = 0; ex_jump = 0;
    mem_regwrite = 0; mem_wreg = 0; wb_regwrite = 0; wb_wreg = 0;
    mem_branch_taken = 0; mem_access = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    RST_N = 0;
    tick();
    tick();
    RST_N = 1;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
  endtask

  task automatic test_reset();
    idle();
    RST_N = 0;
    mem_regwrite = 1; mem_wreg = 5'd5; ex_rs = 5'd5;
    tick();
    checks++;
    if (ctl !== CTL_RST) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_RST); end
    checks++;
    if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got %b want 00", fwd_a); end
    checks++;
    if ({stall_cnt, flush_cnt, mem_timeout} !== '0) begin
      errors++; $display("FAIL reset_state got stall=%0d flush=%0d tmo=%b want 0 0 0", stall_cnt, flush_cnt, mem_timeout);
    end
    idle();
    RST_N = 1;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL reset_release_ctl got %b want %b", ctl, CTL_RUN); end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_idle_cnt got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
  endtask

  typedef struct packed {
    logic       mrw;
    logic [4:0] mw;
    logic       wrw;
    logic [4:0] ww;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] ea;
    logic [1:0] eb;
  } fvec_t;

  task automatic test_forwarding();
    fvec_t fv [6];
    fv[0] = '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 2'b10, 2'b00};
    fv[1] = '{1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5, 2'b01, 2'b01};
    fv[2] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    fv[3] = '{1'b1, 5'd3, 1'b1, 5'd7, 5'd3, 5'd7, 2'b10, 2'b01};
    fv[4] = '{1'b0, 5'd3, 1'b0, 5'd7, 5'd3, 5'd7, 2'b00, 2'b00};
    fv[5] = '{1'b1, 5'd9, 1'b0, 5'd9, 5'd1, 5'd9, 2'b00, 2'b10};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_regwrite = fv[i].mrw; mem_wreg = fv[i].mw;
      wb_regwrite = fv[i].wrw; wb_wreg = fv[i].ww;
      ex_rs = fv[i].rs; ex_rt = fv[i].rt;
      #1;
      checks++;
      if ({fwd_a, fwd_b} !== {fv[i].ea, fv[i].eb}) begin
        errors++; $display("FAIL fwd_vec%0d got a=%b b=%b want a=%b b=%b", i, fwd_a, fwd_b, fv[i].ea, fv[i].eb);
      end
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL fwd_ctl%0d got %b want %b", i, ctl, CTL_RUN); end
      tick();
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      errors++; $display("FAIL fwd_cnt got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_rs_ctl got %b want %b", ctl, CTL_LU); end
    tick();
    checks++;
    if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
      errors++; $display("FAIL lu_cnt got stall=%0d flush=%0d want 1 1", stall_cnt, flush_cnt);
    end
    id_uses_rs = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_unused_ctl got %b want %b", ctl, CTL_RUN); end
    id_uses_rt = 1; id_rt = 5'd8;
    #1;
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_rt_ctl got %b want %b", ctl, CTL_LU); end
    ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rs = 1;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_reg0_ctl got %b want %b", ctl, CTL_RUN); end
    idle();
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_after_idle got stall=%0d want 1", stall_cnt); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_use();
    mem_branch_taken = 1;
    #1;
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL br_over_lu_ctl got %b want %b", ctl, CTL_BR); end
    tick();
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd1) begin
      errors++; $display("FAIL br_cnt got stall=%0d flush=%0d want 0 1", stall_cnt, flush_cnt);
    end
    mem_branch_taken = 0; ex_jump = 1;
    #1;
    checks++;
    if (ctl !== CTL_JMP) begin errors++; $display("FAIL jmp_over_lu_ctl got %b want %b", ctl, CTL_JMP); end
    tick();
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd2) begin
      errors++; $display("FAIL jmp_cnt got stall=%0d flush=%0d want 0 2", stall_cnt, flush_cnt);
    end
    mem_branch_taken = 1;
    #1;
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL br_over_jmp_ctl got %b want %b", ctl, CTL_BR); end
    idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_access = 1; dmem_ready = 1;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL mem_ready_ctl got %b want %b", ctl, CTL_RUN); end
    dmem_ready = 0; ex_jump = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_FREEZE) begin errors++; $display("FAIL freeze_c%0d got %b want %b", i, ctl, CTL_FREEZE); end
      tick();
      ex_jump = 0;
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (ctl !== CTL_JMP) begin errors++; $display("FAIL deferred_jmp_ctl got %b want %b", ctl, CTL_JMP); end
    checks++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0) begin
      errors++; $display("FAIL freeze_cnt got stall=%0d flush=%0d want 3 0", stall_cnt, flush_cnt);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL pend_clear_ctl got %b want %b", ctl, CTL_RUN); end
    checks++;
    if (flush_cnt !== 4'd1) begin errors++; $display("FAIL deferred_flush_cnt got %0d want 1", flush_cnt); end
    mem_access = 1; dmem_ready = 0; mem_branch_taken = 1;
    tick();
    mem_branch_taken = 0;
    tick();
    dmem_ready = 1;
    #1;
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL deferred_br_ctl got %b want %b", ctl, CTL_BR); end
    tick();
    idle();
    #1;
    checks++;
    if (ctl !== CTL_RUN || stall_cnt !== 4'd5) begin
      errors++; $display("FAIL br_release got ctl=%b stall=%0d want %b 5", ctl, stall_cnt, CTL_RUN);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    repeat (20) tick();
    checks++;
    if (stall_cnt !== 4'hF || flush_cnt !== 4'hF) begin
      errors++; $display("FAIL cnt_saturate got stall=%0d flush=%0d want 15 15", stall_cnt, flush_cnt);
    end
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_access = 1; dmem_ready = 0;
    repeat (MEM_TMO) tick();
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", mem_timeout); end
    tick();
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tmo_set got %b want 1", mem_timeout); end
    idle();
    tick();
    tick();
    checks++;
    if (mem_timeout !== 1'b1 || ctl !== CTL_RUN) begin
      errors++; $display("FAIL tmo_sticky got tmo=%b ctl=%b want 1 %b", mem_timeout, ctl, CTL_RUN);
    end
    RST_N = 0;
    tick();
    RST_N = 1;
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL tmo_reset got %b want 0", mem_timeout); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_access = 1; dmem_ready = 0; ex_jump = 1;
    tick();
    ex_jump = 0;
    tick();
    RST_N = 0;
    #1;
    checks++;
    if (ctl !== CTL_RST) begin errors++; $display("FAIL midwait_rst_ctl got %b want %b", ctl, CTL_RST); end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      errors++; $display("FAIL midwait_cnt got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
    RST_N = 1;
    mem_access = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL midwait_release_ctl got %b want %b", ctl, CTL_RUN); end
    tick();
    checks++;
    if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL midwait_no_pend got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_saturation();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
